// File: rtl/regfile_scoreboard.sv
// ID-stage issue interlock: per-register in-flight write counters plus drain sequencer.
// Optional SCOREBOARD_BYPASS_EN lets a source clear its hazard on a same-cycle final WB.
module regfile_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_sr1,
    input  logic                issue_sr1_use,
    input  logic [REG_W-1:0]    issue_sr2,
    input  logic                issue_sr2_use,
    input  logic [REG_W-1:0]    issue_dest,
    input  logic                issue_dest_we,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_dest,
    input  logic                squash_valid,
    input  logic [REG_W-1:0]    squash_dest,
    input  logic                drain_req,
    output logic                stall,
    output logic                issue_accept,
    output logic                drain_done,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                underflow_err
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt      [NUM_REGS];
    logic [CNT_W-1:0] cnt_next [NUM_REGS];
    logic             uf_next;
    logic             all_zero_next;
    logic             sr1_haz, sr2_haz, dest_full;
    logic [CNT_W:0]   sum;
    logic [1:0]       dec;

    always_comb begin
        sr1_haz   = cnt[issue_sr1] != '0;
        sr2_haz   = cnt[issue_sr2] != '0;
        dest_full = cnt[issue_dest] == CNT_MAX;
`ifdef SCOREBOARD_BYPASS_EN
        // last outstanding write lands this cycle; regfile write-through supplies it
        if (wb_valid && wb_dest == issue_sr1 && cnt[issue_sr1] == CNT_ONE)
            sr1_haz = 1'b0;
        if (wb_valid && wb_dest == issue_sr2 && cnt[issue_sr2] == CNT_ONE)
            sr2_haz = 1'b0;
`endif
        stall = (state != RUN) ||
                (issue_valid && ((issue_sr1_use && sr1_haz) ||
                                 (issue_sr2_use && sr2_haz) ||
                                 (issue_dest_we && dest_full)));
        issue_accept = issue_valid && !stall;
    end

    always_comb begin
        uf_next       = underflow_err;
        all_zero_next = 1'b1;
        sum           = '0;
        dec           = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sum = {1'b0, cnt[r]} +
                  (CNT_W+1)'(issue_accept && issue_dest_we && issue_dest == REG_W'(r));
            dec = 2'(wb_valid && wb_dest == REG_W'(r)) +
                  2'(squash_valid && squash_dest == REG_W'(r));
            if ((CNT_W+1)'(dec) > sum) begin
                cnt_next[r] = '0;
                uf_next     = 1'b1;
            end else begin
                cnt_next[r] = CNT_W'(sum - (CNT_W+1)'(dec));
            end
            if (cnt_next[r] != '0)
                all_zero_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        drain_done = 1'b0;
        unique case (state)
            RUN:     if (drain_req) state_next = DRAIN;
            DRAIN:   if (all_zero_next) state_next = DONE;
            DONE: begin
                drain_done = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            underflow_err <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            state         <= state_next;
            underflow_err <= uf_next;
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= cnt_next[r];
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            busy_vec[r] = cnt[r] != '0;
    end

endmodule
